rf_wr_arbiter: RTL
==================

# rf_wr_arbiter

Shares the single register-file write port between the in-order writeback stage and an out-of-band long-latency unit (multi-cycle MDU/divider) whose results return asynchronously to the pipeline. MDU results are buffered in a small FIFO and drained into idle write-port cycles; WB has priority. The block also owns the register dirty-bit scoreboard read by the ID stage for hazard detection. It sits between wb_stage and the register file.

## Interface
- TAG_WIDTH, 4: width of write tag, passed through unchanged.
- BUF_DEPTH, 2: MDU result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 8: cycles a FIFO head may wait before forcing a WB stall (only with RF_WR_ARB_STARVE_EN).

- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wb_wr_en / wb_wr_tag / wb_wr_addr / wb_wr_data  in  1/TAG_WIDTH/5/32  WB write request (the wb_stage rf_wr_* outputs).
- wb_clr_en / wb_clr_addr  in  1/5  clear dirty bit without writing (flushed WB instruction).
- wb_stall  out  1  WB must hold its request this cycle; WB write is not performed.
- mdu_valid / mdu_tag / mdu_addr / mdu_data  in  1/TAG_WIDTH/5/32  MDU result.
- mdu_ready  out  1  FIFO can accept an MDU result.
- mdu_flush  in  1  discard all buffered MDU results.
- set_dirty_en / set_dirty_addr  in  1/5  ID issued instruction writing rd.
- rf_wr_en / rf_wr_tag / rf_wr_addr / rf_wr_data  out  1/TAG_WIDTH/5/32  register-file write port.
- dirty  out  32  scoreboard; bit0 constant 0.

## Operation
- Grant: if wb_stall=0 and wb_wr_en=1 -> WB owns port; else if FIFO non-empty -> FIFO head owns port and pops; else rf_wr_en=0.
- rf_wr_* is combinational from the grant mux; writes to x0 pass through with rf_wr_en=1 (RF ignores).
- FIFO push when mdu_valid & mdu_ready; mdu_ready = ~full (registered count, not dependent on same-cycle pop).
- mdu_flush: FIFO emptied at clock edge; no pop granted that cycle; dirty bits of all valid entries cleared; same-cycle push is dropped (dirty of mdu_addr also cleared).
- Scoreboard, per bit i≠0, next-state priority: set_dirty for i -> 1; else any clear for i (rf_wr_en write to i, wb_clr_en, flushed FIFO entry) -> 0; else hold.
- Set and clear on same address same cycle: set wins (newer producer).
- Starvation counter (with macro): increments each cycle FIFO non-empty and head not granted, saturating at STARVE_LIMIT; reset to 0 on any pop or flush. wb_stall = (count == STARVE_LIMIT) & FIFO non-empty.

## Timing
- Reset: FIFO empty, pointers 0, counter 0, dirty=0, mdu_ready=1, wb_stall=0, rf_wr_en=0.
- MDU result pushed at edge N is eligible for the port in cycle N+1 earliest (no FIFO bypass).
- Write-port latency: 0 cycles from grant to rf_wr_*.
- dirty updates one cycle after set/clear event.
- Full FIFO: mdu_ready=0 the cycle after count reaches BUF_DEPTH; pop and push in same cycle when full is not possible (ready low).
- Pointers wrap modulo BUF_DEPTH; count width clog2(BUF_DEPTH)+1.
- Reset mid-operation drops all buffered entries and scoreboard state immediately.

## Configuration
- RF_WR_ARB_STARVE_EN defined: starvation counter and wb_stall logic present as above.
- Undefined: wb_stall tied 0, counter absent; FIFO drains only in cycles where wb_wr_en=0; STARVE_LIMIT ignored.

## Test plan
- Reset then set_dirty x5, MDU returns x5=0x1234 with WB idle -> dirty[5] 1 then rf_wr_en=1,addr 5,data 0x1234 the cycle after push, dirty[5]=0 next cycle.
- WB writes x3 every cycle while MDU pushes x7 -> WB granted; with macro, wb_stall=1 after 8 waiting cycles, x7 written that cycle, counter 0; without macro x7 written only when wb_wr_en drops.
- Push 2 MDU results with WB busy -> mdu_ready=0; third mdu_valid held, accepted one cycle after first pop.
- set_dirty x9 and rf write x9 same cycle -> dirty[9]=1 afterwards.
- Two entries (x4,x6) buffered, mdu_flush -> FIFO empty, no rf write, dirty[4]=dirty[6]=0 next cycle.
- set_dirty x0 -> dirty[0] stays 0; wb_clr_en x11 -> dirty[11]=0, no rf write.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB has priority, MDU results drain from a small FIFO
// into idle port cycles; also owns the dirty-bit scoreboard. Optional: RF_WR_ARB_STARVE_EN.
module rf_wr_arbiter #(
   parameter int TAG_WIDTH    = 4,
   parameter int BUF_DEPTH    = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wb_wr_en,
   input  logic [TAG_WIDTH-1:0] wb_wr_tag,
   input  logic [4:0]           wb_wr_addr,
   input  logic [31:0]          wb_wr_data,
   input  logic                 wb_clr_en,
   input  logic [4:0]           wb_clr_addr,
   output logic                 wb_stall,
   input  logic                 mdu_valid,
   input  logic [TAG_WIDTH-1:0] mdu_tag,
   input  logic [4:0]           mdu_addr,
   input  logic [31:0]          mdu_data,
   output logic                 mdu_ready,
   input  logic                 mdu_flush,
   input  logic                 set_dirty_en,
   input  logic [4:0]           set_dirty_addr,
   output logic                 rf_wr_en,
   output logic [TAG_WIDTH-1:0] rf_wr_tag,
   output logic [4:0]           rf_wr_addr,
   output logic [31:0]          rf_wr_data,
   output logic [31:0]          dirty
);
   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   logic [TAG_WIDTH-1:0] buf_tag_q  [BUF_DEPTH];
   logic [TAG_WIDTH-1:0] buf_tag_d  [BUF_DEPTH];
   logic [4:0]           buf_addr_q [BUF_DEPTH];
   logic [4:0]           buf_addr_d [BUF_DEPTH];
   logic [31:0]          buf_data_q [BUF_DEPTH];
   logic [31:0]          buf_data_d [BUF_DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [31:0]          dirty_q, dirty_d;
   logic [31:0]          set_mask, clr_mask;
   logic [PTR_W-1:0]     flush_idx;
   logic                 fifo_empty, wb_grant, pop, push;

   assign fifo_empty = (count_q == '0);
   assign mdu_ready  = (count_q != CNT_W'(BUF_DEPTH));
   assign wb_grant   = wb_wr_en & ~wb_stall;
   // A flush cycle never pops: the head is being discarded, not written.
   assign pop        = ~wb_grant & ~fifo_empty & ~mdu_flush;
   assign push       = mdu_valid & mdu_ready & ~mdu_flush;
   assign dirty      = dirty_q;

   always_comb begin
      rf_wr_en   = wb_grant | pop;
      rf_wr_tag  = wb_wr_tag;
      rf_wr_addr = wb_wr_addr;
      rf_wr_data = wb_wr_data;
      if (!wb_grant) begin
         rf_wr_tag  = buf_tag_q[rd_ptr_q];
         rf_wr_addr = buf_addr_q[rd_ptr_q];
         rf_wr_data = buf_data_q[rd_ptr_q];
      end
   end

   always_comb begin
      buf_tag_d  = buf_tag_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (mdu_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            buf_tag_d[wr_ptr_q]  = mdu_tag;
            buf_addr_d[wr_ptr_q] = mdu_addr;
            buf_data_d[wr_ptr_q] = mdu_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Set beats clear on the same bit: the set comes from a newer producer.
   always_comb begin
      set_mask  = '0;
      clr_mask  = '0;
      flush_idx = '0;
      if (set_dirty_en) set_mask[set_dirty_addr] = 1'b1;
      if (rf_wr_en)     clr_mask[rf_wr_addr]     = 1'b1;
      if (wb_clr_en)    clr_mask[wb_clr_addr]    = 1'b1;
      if (mdu_flush) begin
         if (mdu_valid && mdu_ready) clr_mask[mdu_addr] = 1'b1;
         for (int k = 0; k < BUF_DEPTH; k++) begin
            flush_idx = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) clr_mask[buf_addr_q[flush_idx]] = 1'b1;
         end
      end
      dirty_d    = (dirty_q & ~clr_mask) | set_mask;
      dirty_d[0] = 1'b0;
   end

`ifdef RF_WR_ARB_STARVE_EN
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   logic [STV_W-1:0] starve_q, starve_d;

   always_comb begin
      starve_d = starve_q;
      if (pop || mdu_flush)
         starve_d = '0;
      else if (!fifo_empty && (starve_q != STV_W'(STARVE_LIMIT)))
         starve_d = starve_q + 1'b1;
   end

   assign wb_stall = (starve_q == STV_W'(STARVE_LIMIT)) & ~fifo_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) starve_q <= '0;
      else          starve_q <= starve_d;
   end
`else
   // No forced stall: the FIFO drains only in cycles where WB does not write.
   assign wb_stall = 1'b0 & (STARVE_LIMIT > 0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         dirty_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         dirty_q  <= dirty_d;
      end
   end

   // Entry storage is qualified by count/pointers, so it carries no reset.
   always_ff @(posedge clk) begin
      buf_tag_q  <= buf_tag_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
   end

endmodule
